pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_entry.sv | 42 ++++
 rtl/pipe_skid_reg.sv | 139 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register.
//   state_t      : EMPTY/ONE/TWO, encoded so the state value equals the
//                  number of beats held.
//   PIPE_DATA_W  : default datapath payload width.
//   PIPE_CTRL_W  : default control payload width.
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTRL_W = 40;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_entry.sv
// One held beat: valid flag plus data and control payload.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (clears everything)
//   load           : capture d_data/d_ctrl and set valid
//   drop           : clear valid and control (data is left as-is); wins over load
//   zero_ctrl      : when loading, store ctrl=0 instead of d_ctrl (no-op beat)
//   d_data, d_ctrl : payload to load
//   valid, data, ctrl : held contents
module pipe_entry #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              drop,
    input  logic              zero_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (drop) begin
            // ctrl is zeroed whenever valid falls so an idle entry never
            // advertises live control bits.
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= zero_ctrl ? '0 : d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with bubble (no-op insert) and flush, optional skid.
// Build option: define PIPE_SKID_REG_SKID_EN to add the skid entry; in_ready
// then depends only on registered state (no path from out_ready). Without it
// the stage holds at most one beat and in_ready follows out_ready.
// Ports:
//   cpu_clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready           : upstream handshake
//   in_data, in_ctrl            : upstream payload
//   bubble                      : stall upstream, insert a no-op (ctrl=0) beat
//   flush                       : discard all held beats
//   out_valid/out_ready         : downstream handshake
//   out_data, out_ctrl          : head-of-stage payload
//   occ                         : beats held (0..2)
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ
);

    state_t            state;
    logic              room, go_in, go_out;
    logic              main_load, main_drop, main_zero;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;

`ifdef PIPE_SKID_REG_SKID_EN
    logic              skid_valid, skid_load, skid_drop;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign room = (state != TWO);
`else
    assign room = !out_valid || out_ready;
`endif

    assign in_ready = room && !bubble && !reset;
    // A bubble takes the slot a real beat would, whether or not one is offered.
    assign go_in    = !reset && !flush && room && (bubble || in_valid);
    assign go_out   = out_valid && out_ready;

    always_comb begin
        main_load   = 1'b0;
        main_drop   = flush;
        main_zero   = bubble;
        main_d_data = in_data;
        main_d_ctrl = in_ctrl;
        if (!flush) begin
            case (state)
                EMPTY: main_load = go_in;
                ONE: begin
                    if (go_out) begin
                        if (go_in) main_load = 1'b1;
                        else       main_drop = 1'b1;
                    end
                end
`ifdef PIPE_SKID_REG_SKID_EN
                TWO: begin
                    // promote the older skid beat into the head slot
                    main_load   = go_out;
                    main_d_data = skid_data;
                    main_d_ctrl = skid_ctrl;
                    main_zero   = 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset || flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (go_in) state <= ONE;
                ONE: begin
`ifdef PIPE_SKID_REG_SKID_EN
                    if (go_in && !go_out) state <= TWO;
                    else
`endif
                    if (!go_in && go_out) state <= EMPTY;
                end
                TWO: if (go_out) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    assign occ = state;

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk       (cpu_clk),
        .reset     (reset),
        .load      (main_load),
        .drop      (main_drop),
        .zero_ctrl (main_zero),
        .d_data    (main_d_data),
        .d_ctrl    (main_d_ctrl),
        .valid     (out_valid),
        .data      (out_data),
        .ctrl      (out_ctrl)
    );

`ifdef PIPE_SKID_REG_SKID_EN
    // Skid fills only when the head is stalled and a beat arrives, so it is
    // always younger than main and older than anything still upstream.
    assign skid_load = (state == ONE) && go_in && !go_out;
    assign skid_drop = flush || ((state == TWO) && go_out);

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk       (cpu_clk),
        .reset     (reset),
        .load      (skid_load),
        .drop      (skid_drop),
        .zero_ctrl (bubble),
        .d_data    (in_data),
        .d_ctrl    (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg; covers both builds via the same macro.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = 40;

    logic          cpu_clk = 1'b0;
    logic          reset, in_valid, in_ready, bubble, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occ;

    int n_vec = 0;
    int n_err = 0;

    always #5 cpu_clk = ~cpu_clk;

    pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .cpu_clk   (cpu_clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .bubble    (bubble),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occ       (occ)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [CW-1:0] c, input logic [1:0] o);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".out_data"},  64'(out_data),  64'(d));
        chk({tag, ".out_ctrl"},  64'(out_ctrl),  64'(c));
        chk({tag, ".occ"},       64'(occ),       64'(o));
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        reset = 1'b1; bubble = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0);
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        tick(); tick();
        chk_out("rst", 1'b0, '0, '0, 2'd0);
        reset = 1'b0;
        #1;
        chk("rel.in_ready", 64'(in_ready), 64'd1);

        // single beat, latency 1
        @(negedge cpu_clk);
        out_ready = 1'b1;
        drive(1'b1, 32'h0040_0004, 40'h15);
        tick();
        drive(1'b0, '0, '0);
        chk_out("lat1", 1'b1, 32'h0040_0004, 40'h15, 2'd1);
        tick();
        chk_out("drain", 1'b0, 32'h0040_0004, '0, 2'd0);

        // head stalled, second beat offered
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 40'h1);
        tick();
        drive(1'b1, 32'h22, 40'h2);
        #1;
`ifdef PIPE_SKID_REG_SKID_EN
        chk("skid.in_ready_one", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, '0, '0);
        #1;
        chk("skid.in_ready_two", 64'(in_ready), 64'd0);
        chk_out("skid.full", 1'b1, 32'h11, 40'h1, 2'd2);
        out_ready = 1'b1;
        #1;
        chk("skid.in_ready_noor", 64'(in_ready), 64'd0);
        tick();
        chk_out("skid.b", 1'b1, 32'h22, 40'h2, 2'd1);
        tick();
        chk_out("skid.empty", 1'b0, 32'h22, '0, 2'd0);

        // two held, flush while head is being taken
        out_ready = 1'b0;
        drive(1'b1, 32'h33, 40'h3);
        tick();
        drive(1'b1, 32'h44, 40'h4);
        tick();
        drive(1'b0, '0, '0);
        chk("fl2.occ", 64'(occ), 64'd2);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("fl2.head_taken", 64'({out_valid, out_data}), {31'd0, 1'b1, 32'h33});
        tick();
        flush = 1'b0;
        chk_out("fl2", 1'b0, 32'h33, '0, 2'd0);
`else
        chk("hold.in_ready_stall", 64'(in_ready), 64'd0);
        tick();
        chk_out("hold", 1'b1, 32'h11, 40'h1, 2'd1);
        out_ready = 1'b1;
        #1;
        chk("hold.in_ready_comb", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, '0, '0);
        chk_out("swap", 1'b1, 32'h22, 40'h2, 2'd1);
        tick();
        chk_out("swap.empty", 1'b0, 32'h22, '0, 2'd0);
`endif

        // bubble: no-op beat carrying datapath value, upstream held
        out_ready = 1'b1;
        bubble = 1'b1;
        drive(1'b1, 32'hDEAD, 40'hFF);
        #1;
        chk("bub.in_ready", 64'(in_ready), 64'd0);
        tick();
        bubble = 1'b0;
        drive(1'b0, '0, '0);
        chk_out("bub", 1'b1, 32'hDEAD, '0, 2'd1);
        tick();
        chk_out("bub.empty", 1'b0, 32'hDEAD, '0, 2'd0);

        // flush beats bubble: nothing loaded
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 40'h5);
        tick();
        chk("fb.occ_pre", 64'(occ), 64'd1);
        flush = 1'b1;
        bubble = 1'b1;
        drive(1'b1, 32'h66, 40'h6);
        tick();
        flush = 1'b0;
        bubble = 1'b0;
        drive(1'b0, '0, '0);
        chk_out("fb", 1'b0, 32'h55, '0, 2'd0);
        tick();
        chk_out("fb.after", 1'b0, 32'h55, '0, 2'd0);

        // flush drops a same-cycle input on an empty stage
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h77, 40'h7);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("fin.out_valid", 64'(out_valid), 64'd0);

        // reset mid-transfer
        out_ready = 1'b0;
        drive(1'b1, 32'h88, 40'h8);
        tick();
        drive(1'b0, '0, '0);
        chk("rmid.occ_pre", 64'(occ), 64'd1);
        reset = 1'b1;
        #1;
        chk("rmid.in_ready", 64'(in_ready), 64'd0);
        tick();
        chk_out("rmid", 1'b0, '0, '0, 2'd0);
        reset = 1'b0;
        #1;
        chk("rmid.rel_in_ready", 64'(in_ready), 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
